// File: rtl/data_path_pkg.sv
// Shared types and constants for the single-cycle data_path block.
package data_path_pkg;

    localparam int DATA_W  = 8;
    localparam int NREGS   = 16;
    localparam int INSTR_W = 14;
    localparam int FIELD_W = 4;

    localparam int OP_MSB = 13;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int A_MSB  = 7;
    localparam int A_LSB  = 4;
    localparam int B_MSB  = 3;
    localparam int B_LSB  = 0;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } opcode_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: ADD/SUB/AND/OR with Z, N, C, V status flags.
module alu
    import data_path_pkg::*;
#(
    parameter int W = data_path_pkg::DATA_W
) (
    input  opcode_e        op_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [W-1:0]   r_o,
    output flags_t         flags_o
);

    logic [W:0] sumExt;
    logic [W:0] diffExt;

    // SUB is A + ~B + 1, so the carry-out doubles as the no-borrow flag.
    always_comb begin
        sumExt    = {1'b0, a_i} + {1'b0, b_i};
        diffExt   = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
        r_o       = '0;
        flags_o   = '0;
        case (op_i)
            OP_ADD: begin
                r_o       = sumExt[W-1:0];
                flags_o.c = sumExt[W];
                flags_o.v = (a_i[W-1] == b_i[W-1]) && (sumExt[W-1] != a_i[W-1]);
            end
            OP_SUB: begin
                r_o       = diffExt[W-1:0];
                flags_o.c = diffExt[W];
                flags_o.v = (a_i[W-1] != b_i[W-1]) && (diffExt[W-1] != a_i[W-1]);
            end
            OP_AND: r_o = a_i & b_i;
            OP_OR:  r_o = a_i | b_i;
            default: r_o = '0;
        endcase
        flags_o.z = (r_o == '0);
        flags_o.n = r_o[W-1];
    end

endmodule

// File: rtl/data_path.sv
// Single-cycle datapath: decode, ALU, 16-entry register file, registered result and flags.
module data_path
    import data_path_pkg::*;
#(
    parameter int DATA_W = data_path_pkg::DATA_W,
    parameter int NREGS  = data_path_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INSTR_W-1:0]       instruction,
    output logic                     flag_zero,
    output logic                     flag_negative,
    output logic                     flag_carry,
    output logic                     flag_overflow,
    output logic [DATA_W-1:0]        result,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    opcode_e                  opCode;
    logic [RD_MSB-RD_LSB:0]   rdAddr;
    logic [DATA_W-1:0]        opA;
    logic [DATA_W-1:0]        opB;
    logic [DATA_W-1:0]        result_d;
    flags_t                   flags_d;

    logic [DATA_W-1:0]        regFile_q [NREGS];
    logic [DATA_W-1:0]        result_q;
    flags_t                   flags_q;

    assign opCode = opcode_e'(instruction[OP_MSB:OP_LSB]);
    assign rdAddr = instruction[RD_MSB:RD_LSB];
    assign opA    = {{(DATA_W-FIELD_W){1'b0}}, instruction[A_MSB:A_LSB]};
    assign opB    = {{(DATA_W-FIELD_W){1'b0}}, instruction[B_MSB:B_LSB]};

    alu #(.W(DATA_W)) u_alu (
        .op_i    (opCode),
        .a_i     (opA),
        .b_i     (opB),
        .r_o     (result_d),
        .flags_o (flags_d)
    );

    // Reset wins over the instruction: nothing is written during a reset cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile_q[i] <= '0;
            end
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            regFile_q[rdAddr] <= result_d;
            result_q          <= result_d;
            flags_q           <= flags_d;
        end
    end

    assign result        = result_q;
    assign flag_zero     = flags_q.z;
    assign flag_negative = flags_q.n;
    assign flag_carry    = flags_q.c;
    assign flag_overflow = flags_q.v;
    assign dbg_data      = regFile_q[dbg_addr];

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: arithmetic reference model plus hand-computed directed checks.
module tb_data_path;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] instruction = '0;
    logic        flag_zero;
    logic        flag_negative;
    logic        flag_carry;
    logic        flag_overflow;
    logic [7:0]  result;
    logic [3:0]  dbg_addr = '0;
    logic [7:0]  dbg_data;

    int checks = 0;
    int errors = 0;
    bit compareEn = 1'b0;

    int         modelRegs [16];
    int         modelResult;
    logic [3:0] modelFlags;

    data_path dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .flag_zero     (flag_zero),
        .flag_negative (flag_negative),
        .flag_carry    (flag_carry),
        .flag_overflow (flag_overflow),
        .result        (result),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    always #5 clk = ~clk;

    // Reference model: integer arithmetic on the operand values, wrapped to 8 bits.
    always @(posedge clk) begin
        int a, b, sa, sb, r, sr;
        bit c, v;
        if (reset) begin
            for (int i = 0; i < 16; i++) modelRegs[i] = 0;
            modelResult = 0;
            modelFlags  = 4'b0000;
        end else begin
            a  = int'(instruction[7:4]);
            b  = int'(instruction[3:0]);
            sa = (a > 127) ? a - 256 : a;
            sb = (b > 127) ? b - 256 : b;
            c  = 1'b0;
            v  = 1'b0;
            case (instruction[13:12])
                2'd0: begin
                    r  = a + b;
                    sr = sa + sb;
                    c  = (r > 255);
                    v  = (sr > 127) || (sr < -128);
                end
                2'd1: begin
                    r  = a - b;
                    sr = sa - sb;
                    c  = (a >= b);
                    v  = (sr > 127) || (sr < -128);
                end
                2'd2: r = a & b;
                default: r = a | b;
            endcase
            r = ((r % 256) + 256) % 256;
            modelResult = r;
            modelFlags  = {r == 0, r >= 128, c, v};
            modelRegs[int'(instruction[11:8])] = r;
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkLiteral(input string name, input logic [7:0] expResult, input logic [3:0] expFlags);
        checkOutput({name, " result"}, result, expResult);
        checkOutput({name, " flags"},
                    {4'b0, flag_zero, flag_negative, flag_carry, flag_overflow},
                    {4'b0, expFlags});
    endtask

    task automatic checkReg(input string name, input logic [3:0] addr, input logic [7:0] expected);
        dbg_addr = addr;
        #1;
        checkOutput(name, dbg_data, expected);
    endtask

    // Drive an instruction between edges; return just after the edge that executes it.
    task automatic applyStimulus(input logic [13:0] instr, input logic rst);
        @(negedge clk);
        instruction = instr;
        reset       = rst;
        dbg_addr    = instr[11:8];
        @(posedge clk);
        #2;
    endtask

    // Compare process: DUT against the model on every falling edge once the model is initialised.
    always @(negedge clk) begin
        if (compareEn) begin
            checkOutput("model result", result, 8'(modelResult));
            checkOutput("model flags",
                        {4'b0, flag_zero, flag_negative, flag_carry, flag_overflow},
                        {4'b0, modelFlags});
            checkOutput("model dbg_data", dbg_data, 8'(modelRegs[int'(dbg_addr)]));
        end
    end

    initial begin
        $display("[TB] starting data_path test");
        applyStimulus(14'b00_0111_0101_0011, 1'b1);
        compareEn = 1'b1;
        applyStimulus(14'b00_0111_0101_0011, 1'b1);
        checkLiteral("reset", 8'h00, 4'b0000);
        for (int i = 0; i < 16; i++) checkReg("reset dbg_data", 4'(i), 8'h00);

        applyStimulus(14'b00_1010_1111_0000, 1'b0);
        checkLiteral("add 15+0", 8'd15, 4'b0000);
        applyStimulus(14'b00_1010_0000_1111, 1'b0);
        checkLiteral("add 0+15", 8'd15, 4'b0000);
        checkReg("reg10 after add", 4'd10, 8'd15);

        applyStimulus(14'b01_1010_0001_0001, 1'b0);
        checkLiteral("sub 1-1", 8'h00, 4'b1010);
        applyStimulus(14'b01_1010_0001_0001, 1'b0);
        checkLiteral("sub 1-1 repeat", 8'h00, 4'b1010);

        applyStimulus(14'b01_1010_0000_0001, 1'b0);
        checkLiteral("sub 0-1", 8'hFF, 4'b0100);
        applyStimulus(14'b01_1010_0000_0001, 1'b0);
        checkLiteral("sub 0-1 repeat", 8'hFF, 4'b0100);

        applyStimulus(14'b10_0011_1100_1010, 1'b0);
        checkLiteral("and", 8'd8, 4'b0000);
        applyStimulus(14'b11_0100_1100_0011, 1'b0);
        checkLiteral("or", 8'd15, 4'b0000);
        checkReg("reg3 after and", 4'd3, 8'd8);
        checkReg("reg4 after or", 4'd4, 8'd15);

        applyStimulus(14'b00_0001_1111_1111, 1'b0);
        checkLiteral("add 15+15", 8'd30, 4'b0000);
        applyStimulus(14'b01_0010_0000_1111, 1'b0);
        checkLiteral("sub 0-15", 8'hF1, 4'b0100);
        applyStimulus(14'b01_0010_1001_0100, 1'b0);
        checkLiteral("sub 9-4", 8'd5, 4'b0010);
        applyStimulus(14'b10_0110_1010_0101, 1'b0);
        checkLiteral("and disjoint", 8'h00, 4'b1000);

        applyStimulus(14'b00_0101_0011_0100, 1'b1);
        checkLiteral("reset mid-sequence", 8'h00, 4'b0000);
        checkReg("reg5 during reset", 4'd5, 8'h00);
        checkReg("reg10 cleared by reset", 4'd10, 8'h00);
        applyStimulus(14'b00_0101_0011_0100, 1'b0);
        checkLiteral("add after reset", 8'd7, 4'b0000);
        checkReg("reg5 after resume", 4'd5, 8'd7);

        applyStimulus(14'b11_1111_1000_0001, 1'b0);
        checkLiteral("or to reg15", 8'd9, 4'b0000);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
